// File: rtl/bt_uart_pkg.sv
`default_nettype none
// ============================================================================
// Module  : bt_uart_pkg
// Purpose : Shared types and constants for the HC-05 UART receive path.
// Rev     : 1.0  initial release
// ============================================================================
package bt_uart_pkg;

   localparam int unsigned DEFAULT_CLKS_PER_BIT = 104;  // 1 MHz / 9600 baud

   localparam logic [7:0] ASCII_CR = 8'h0D;
   localparam logic [7:0] ASCII_LF = 8'h0A;

   typedef enum logic [2:0] {
      RX_IDLE      = 3'd0,
      RX_START     = 3'd1,
      RX_DATA      = 3'd2,
      RX_STOP      = 3'd3,
      RX_WAIT_HIGH = 3'd4
   } rx_state_t;

endpackage
`default_nettype wire

// File: rtl/uart_rx_byte.sv
`default_nettype none
// ============================================================================
// Module  : uart_rx_byte
// Purpose : 8N1 deserialiser with 2-flop input synchroniser; emits a
//           single-cycle byte strobe or frame-error strobe at the stop sample.
// Rev     : 1.0  initial release
// ============================================================================
module uart_rx_byte
   import bt_uart_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
   input  logic       CLK1MHZ,
   input  logic       resetn,
   input  logic       rx_in,
   input  logic       enable,
   output logic [7:0] byte_data,
   output logic       byte_valid,
   output logic       byte_ferr,
   output logic       in_idle
);

   localparam int unsigned CW = $clog2(CLKS_PER_BIT + 1);
   localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);

   logic [1:0]    r_sync;
   rx_state_t     r_state;
   rx_state_t     w_state_next;
   logic [CW-1:0] r_cnt;
   logic [CW-1:0] w_cnt_next;
   logic [2:0]    r_bit_idx;
   logic [2:0]    w_bit_idx_next;
   logic [7:0]    r_shift;
   logic [7:0]    w_shift_next;
   logic          w_rx;
   logic          w_expired;
   logic          w_accept;
   logic          w_ferr;

   always_ff @(posedge CLK1MHZ or negedge resetn) begin
      if (!resetn) r_sync <= 2'b11;
      else         r_sync <= {r_sync[0], rx_in};
   end

   assign w_rx      = r_sync[1];
   assign w_expired = (r_cnt == '0);

   always_ff @(posedge CLK1MHZ or negedge resetn) begin
      if (!resetn) begin
         r_state   <= RX_IDLE;
         r_cnt     <= '0;
         r_bit_idx <= '0;
         r_shift   <= '0;
      end else begin
         r_state   <= w_state_next;
         r_cnt     <= w_cnt_next;
         r_bit_idx <= w_bit_idx_next;
         r_shift   <= w_shift_next;
      end
   end

   // A load of N gives the next sample N+1 cycles later.
   always_comb begin
      w_state_next   = r_state;
      w_cnt_next     = r_cnt;
      w_bit_idx_next = r_bit_idx;
      w_shift_next   = r_shift;
      w_accept       = 1'b0;
      w_ferr         = 1'b0;
      case (r_state)
         RX_IDLE: begin
            if (enable && !w_rx) begin
               w_cnt_next   = HALF_M1;
               w_state_next = RX_START;
            end
         end
         RX_START: begin
            if (w_expired) begin
               if (!w_rx) begin
                  w_cnt_next     = FULL_M1;
                  w_bit_idx_next = '0;
                  w_state_next   = RX_DATA;
               end else begin
                  w_state_next = RX_IDLE;
               end
            end else begin
               w_cnt_next = r_cnt - 1'b1;
            end
         end
         RX_DATA: begin
            if (w_expired) begin
               w_shift_next = {w_rx, r_shift[7:1]};
               w_cnt_next   = FULL_M1;
               if (r_bit_idx == 3'd7) w_state_next = RX_STOP;
               else                   w_bit_idx_next = r_bit_idx + 1'b1;
            end else begin
               w_cnt_next = r_cnt - 1'b1;
            end
         end
         RX_STOP: begin
            if (w_expired) begin
               if (w_rx) begin
                  w_accept     = 1'b1;
                  w_state_next = RX_IDLE;
               end else begin
                  w_ferr       = 1'b1;
                  w_state_next = RX_WAIT_HIGH;
               end
            end else begin
               w_cnt_next = r_cnt - 1'b1;
            end
         end
         RX_WAIT_HIGH: begin
            if (w_rx) w_state_next = RX_IDLE;
         end
         default: w_state_next = RX_IDLE;
      endcase
   end

   assign byte_data  = r_shift;
   assign byte_valid = w_accept;
   assign byte_ferr  = w_ferr;
   assign in_idle    = (r_state == RX_IDLE);

endmodule
`default_nettype wire

// File: rtl/bt_uart_rx_packer.sv
`default_nettype none
// ============================================================================
// Module  : bt_uart_rx_packer
// Purpose : Packs received UART bytes into 16-bit FIFO words and flags the
//           CR,LF terminator. Optional build macro RX_IDLE_FLUSH_EN flushes
//           a lone high byte after an idle timeout.
// Rev     : 1.0  initial release
// ============================================================================
module bt_uart_rx_packer
   import bt_uart_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT    = DEFAULT_CLKS_PER_BIT,
   parameter int unsigned IDLE_FLUSH_BITS = 20,
   parameter logic [7:0]  PAD_BYTE        = 8'h00
) (
   input  logic        CLK1MHZ,
   input  logic        resetn,
   input  logic        rx_in,
   input  logic        enable,
   input  logic        fifo_full,
   output logic [15:0] word_out,
   output logic        word_valid,
   output logic        line_end,
   output logic        frame_error,
   output logic        overflow
);

   logic [7:0]  w_byte;
   logic        w_byte_valid;
   logic        w_byte_ferr;
   logic        w_in_idle;

   logic        r_have_high;
   logic [7:0]  r_high;
   logic        r_cr_flag;
   logic        w_have_high_next;
   logic [7:0]  w_high_next;
   logic        w_cr_next;
   logic        w_emit;
   logic [15:0] w_emit_word;
   logic        w_emit_le;
   logic        w_term;
   logic        w_flush;

   uart_rx_byte #(
      .CLKS_PER_BIT (CLKS_PER_BIT)
   ) u_rx (
      .CLK1MHZ    (CLK1MHZ),
      .resetn     (resetn),
      .rx_in      (rx_in),
      .enable     (enable),
      .byte_data  (w_byte),
      .byte_valid (w_byte_valid),
      .byte_ferr  (w_byte_ferr),
      .in_idle    (w_in_idle)
   );

`ifdef RX_IDLE_FLUSH_EN
   localparam int unsigned FLUSH_CYCLES = IDLE_FLUSH_BITS * CLKS_PER_BIT;
   localparam int unsigned FW           = $clog2(FLUSH_CYCLES + 1);
   localparam logic [FW-1:0] FLUSH_LAST = FW'(FLUSH_CYCLES - 1);

   logic [FW-1:0] r_flush_cnt;

   // Leaving IDLE (i.e. any start bit, even a glitch) restarts the timeout.
   always_ff @(posedge CLK1MHZ or negedge resetn) begin
      if (!resetn)                                 r_flush_cnt <= '0;
      else if (!w_in_idle || !r_have_high || w_flush) r_flush_cnt <= '0;
      else                                         r_flush_cnt <= r_flush_cnt + 1'b1;
   end

   assign w_flush = w_in_idle && r_have_high && (r_flush_cnt == FLUSH_LAST);
`else
   assign w_flush = 1'b0;
`endif

   assign w_term = (w_byte == ASCII_LF) && r_cr_flag;

   always_comb begin
      w_have_high_next = r_have_high;
      w_high_next      = r_high;
      w_cr_next        = r_cr_flag;
      w_emit           = 1'b0;
      w_emit_word      = {r_high, w_byte};
      w_emit_le        = 1'b0;
      if (w_byte_valid) begin
         w_cr_next = (w_byte == ASCII_CR);
         if (r_have_high) begin
            w_emit           = 1'b1;
            w_emit_le        = w_term;
            w_have_high_next = 1'b0;
         end else if (w_term) begin
            w_emit      = 1'b1;
            w_emit_word = {ASCII_LF, PAD_BYTE};
            w_emit_le   = 1'b1;
         end else begin
            w_high_next      = w_byte;
            w_have_high_next = 1'b1;
         end
      end else if (w_in_idle && !enable) begin
         w_have_high_next = 1'b0;
         w_cr_next        = 1'b0;
      end else if (w_flush) begin
         w_emit           = 1'b1;
         w_emit_word      = {r_high, PAD_BYTE};
         w_have_high_next = 1'b0;
      end
   end

   // line_end is not gated by fifo_full so the controlling FSM always advances.
   always_ff @(posedge CLK1MHZ or negedge resetn) begin
      if (!resetn) begin
         r_have_high <= 1'b0;
         r_high      <= '0;
         r_cr_flag   <= 1'b0;
         word_out    <= '0;
         word_valid  <= 1'b0;
         line_end    <= 1'b0;
         frame_error <= 1'b0;
         overflow    <= 1'b0;
      end else begin
         r_have_high <= w_have_high_next;
         r_high      <= w_high_next;
         r_cr_flag   <= w_cr_next;
         word_valid  <= w_emit && !fifo_full;
         line_end    <= w_emit_le;
         frame_error <= w_byte_ferr;
         if (w_emit && !fifo_full) word_out <= w_emit_word;
         if (w_emit && fifo_full)  overflow <= 1'b1;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_bt_uart_rx_packer.sv
`default_nettype none
// ============================================================================
// Module  : tb_bt_uart_rx_packer
// Purpose : Directed self-checking bench with an expected-word scoreboard.
// Rev     : 1.0  initial release
// ============================================================================
module tb_bt_uart_rx_packer;

   localparam int BIT = 104;

   logic        CLK1MHZ = 1'b0;
   logic        resetn  = 1'b0;
   logic        rx_in   = 1'b1;
   logic        enable  = 1'b0;
   logic        fifo_full = 1'b0;
   logic [15:0] word_out;
   logic        word_valid;
   logic        line_end;
   logic        frame_error;
   logic        overflow;

   int checks = 0;
   int errors = 0;
   int fe_count = 0;

   typedef struct packed {
      logic [15:0] word;
      logic        le;
      logic        valid;
   } exp_t;
   exp_t exp_q[$];

   bt_uart_rx_packer dut (
      .CLK1MHZ     (CLK1MHZ),
      .resetn      (resetn),
      .rx_in       (rx_in),
      .enable      (enable),
      .fifo_full   (fifo_full),
      .word_out    (word_out),
      .word_valid  (word_valid),
      .line_end    (line_end),
      .frame_error (frame_error),
      .overflow    (overflow)
   );

   always #5 CLK1MHZ = ~CLK1MHZ;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic expect_word(input logic [15:0] w, input logic le, input logic v);
      exp_t e;
      e.word = w; e.le = le; e.valid = v;
      exp_q.push_back(e);
   endtask

   task automatic send_byte(input logic [7:0] b, input logic stop_bit);
      @(negedge CLK1MHZ);
      rx_in = 1'b0;
      repeat (BIT) @(negedge CLK1MHZ);
      for (int i = 0; i < 8; i++) begin
         rx_in = b[i];
         repeat (BIT) @(negedge CLK1MHZ);
      end
      rx_in = stop_bit;
      repeat (BIT) @(negedge CLK1MHZ);
      rx_in = 1'b1;
      repeat (20) @(negedge CLK1MHZ);
   endtask

   always @(negedge CLK1MHZ) begin
      if (resetn && frame_error) fe_count++;
      if (resetn && (word_valid || line_end)) begin
         if (exp_q.size() == 0) begin
            check("unexpected_output", {13'd0, word_valid, line_end, 1'b0, word_out}, 32'd0);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            check("word_valid", {31'd0, word_valid}, {31'd0, e.valid});
            check("line_end", {31'd0, line_end}, {31'd0, e.le});
            if (e.valid) check("word_out", {16'd0, word_out}, {16'd0, e.word});
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

   initial begin
      resetn = 1'b0;
      repeat (5) @(negedge CLK1MHZ);
      check("reset_word_out", {16'd0, word_out}, 32'd0);
      check("reset_word_valid", {31'd0, word_valid}, 32'd0);
      check("reset_line_end", {31'd0, line_end}, 32'd0);
      check("reset_frame_error", {31'd0, frame_error}, 32'd0);
      check("reset_overflow", {31'd0, overflow}, 32'd0);
      resetn = 1'b1;
      enable = 1'b1;
      repeat (10) @(negedge CLK1MHZ);

      // "OK\r\n"
      expect_word(16'h4F4B, 1'b0, 1'b1);
      expect_word(16'h0D0A, 1'b1, 1'b1);
      send_byte("O", 1'b1); send_byte("K", 1'b1);
      send_byte(8'h0D, 1'b1); send_byte(8'h0A, 1'b1);
      check("ok_queue_drained", exp_q.size(), 32'd0);
      check("ok_overflow", {31'd0, overflow}, 32'd0);

      // "A\r\n": LF lands in the high byte
      expect_word(16'h410D, 1'b0, 1'b1);
      expect_word(16'h0A00, 1'b1, 1'b1);
      send_byte("A", 1'b1); send_byte(8'h0D, 1'b1); send_byte(8'h0A, 1'b1);
      check("a_queue_drained", exp_q.size(), 32'd0);

      // 20-cycle glitch on the line
      @(negedge CLK1MHZ);
      rx_in = 1'b0;
      repeat (20) @(negedge CLK1MHZ);
      rx_in = 1'b1;
      repeat (300) @(negedge CLK1MHZ);
      check("glitch_no_frame_error", fe_count, 32'd0);

      // Frame error, then "HI" proves nothing was stored
      send_byte(8'h55, 1'b0);
      check("frame_error_count", fe_count, 32'd1);
      expect_word(16'h4849, 1'b0, 1'b1);
      send_byte("H", 1'b1); send_byte("I", 1'b1);
      check("hi_queue_drained", exp_q.size(), 32'd0);

      // FIFO full during "\r\n"
      fifo_full = 1'b1;
      expect_word(16'h0D0A, 1'b1, 1'b0);
      send_byte(8'h0D, 1'b1); send_byte(8'h0A, 1'b1);
      fifo_full = 1'b0;
      check("full_queue_drained", exp_q.size(), 32'd0);
      check("overflow_set", {31'd0, overflow}, 32'd1);
      check("word_out_held", {16'd0, word_out}, 32'h4849);

      // Pending high byte "Q", then reset mid-byte
      send_byte("Q", 1'b1);
      check("overflow_sticky", {31'd0, overflow}, 32'd1);
      @(negedge CLK1MHZ);
      rx_in = 1'b0;
      repeat (300) @(negedge CLK1MHZ);
      #2 resetn = 1'b0;
      #1;
      check("midreset_word_out", {16'd0, word_out}, 32'd0);
      check("midreset_word_valid", {31'd0, word_valid}, 32'd0);
      check("midreset_line_end", {31'd0, line_end}, 32'd0);
      check("midreset_frame_error", {31'd0, frame_error}, 32'd0);
      check("midreset_overflow", {31'd0, overflow}, 32'd0);
      rx_in = 1'b1;
      repeat (5) @(negedge CLK1MHZ);
      resetn = 1'b1;
      repeat (5) @(negedge CLK1MHZ);
      expect_word(16'h5859, 1'b0, 1'b1);
      send_byte("X", 1'b1); send_byte("Y", 1'b1);
      check("xy_queue_drained", exp_q.size(), 32'd0);

      // Lone high byte followed by a long idle
`ifdef RX_IDLE_FLUSH_EN
      expect_word(16'h5A00, 1'b0, 1'b1);
`endif
      send_byte("Z", 1'b1);
      repeat (2100) @(negedge CLK1MHZ);
      check("idle_queue_drained", exp_q.size(), 32'd0);

      // Dropping enable in IDLE discards any pending high byte
      enable = 1'b0;
      repeat (5) @(negedge CLK1MHZ);
      enable = 1'b1;
      expect_word(16'h3132, 1'b0, 1'b1);
      send_byte("1", 1'b1); send_byte("2", 1'b1);
      repeat (50) @(negedge CLK1MHZ);
      check("final_queue_drained", exp_q.size(), 32'd0);
      check("final_frame_errors", fe_count, 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
